multi_segment_counter: RTL

MULTI_SEGMENT_COUNTER -- requirements
Module: multi_segment_counter

---
 rtl/seg7_pkg.sv | 56 +++++
 rtl/multi_segment_counter_if.sv | 43 ++++
 rtl/seg7_decoder.sv | 22 ++
 rtl/multi_segment_counter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared 7-segment constants. Holds the segment bit positions,
//               the BCD decode table and the pattern shown for non-BCD input.
//               seg7_decode() is the single decode implementation; it is used
//               by seg7_decoder.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Bit positions inside the 8-bit segment bus
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  localparam int SEG_W  = 7;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Decode table, entry d holds segments g..a for digit d
  localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
    7'b1101111,   // 9
    7'b1111111,   // 8
    7'b0000111,   // 7
    7'b1111101,   // 6
    7'b1101101,   // 5
    7'b1100110,   // 4
    7'b1001111,   // 3
    7'b1011011,   // 2
    7'b0000110,   // 1
    7'b0111111    // 0
  };

  // "E" shown for any value outside 0..9
  localparam logic [SEG_W-1:0] SEG_ERR = 7'b1111001;

  function automatic logic [SEG_W-1:0] seg7_decode(input logic [3:0] digit);
    logic [SEG_W-1:0] seg;
    seg = SEG_ERR;
    // Constant-index compare keeps the table access in range for 10..15
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) begin
        seg = SEG_TABLE[i];
      end
    end
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_segment_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_segment_counter_if
// Description : Control and display bus of the multiplexed BCD counter.
// Ports       : enable, clear            - controller -> counter
//               segment_out, digit_sel,
//               tick_out, overflow       - counter -> controller / display
//               master modport = controller side, slave modport = counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_segment_counter_if
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4
);

  logic                enable;
  logic                clear;
  logic [SEG_W:0]      segment_out;
  logic [N_DIGITS-1:0] digit_sel;
  logic                tick_out;
  logic                overflow;

  modport master (
    output enable,
    output clear,
    input  segment_out,
    input  digit_sel,
    input  tick_out,
    input  overflow
  );

  modport slave (
    input  enable,
    input  clear,
    output segment_out,
    output digit_sel,
    output tick_out,
    output overflow
  );

endinterface
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decoder
// Description : Combinational 4-bit to 7-segment decoder (segments g..a).
//               Non-BCD values show "E".
// Ports       : digit_i [3:0] - digit value
//               seg_o   [6:0] - active-high segments, bit0 = a
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0]       digit_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = seg7_decode(digit_i);
  end

endmodule
`default_nettype wire

// File: rtl/multi_segment_counter.sv
`default_nettype none
// ============================================================================
// Module      : multi_segment_counter
// Description : N_DIGITS BCD event counter with a tick prescaler and a
//               time-multiplexed 7-segment display driver. dp toggles per
//               tick and is shown on digit 0 only; leading zeros optionally
//               blanked; outputs optionally active-low.
// Ports       : CLOCK - clock, rising edge
//               RESET - synchronous active-high reset
//               bus   - slave modport: enable, clear in;
//                       segment_out, digit_sel, tick_out, overflow out
// Revision    : 1.0 - initial release
// ============================================================================
module multi_segment_counter
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned TICK_DIV      = 32'h200000,
  parameter int unsigned SCAN_DIV      = 5000,
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  multi_segment_counter_if.slave  bus
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0]   SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);

  // Polarity is folded into the output registers, so reset values carry it too
  localparam logic [SEG_W:0]      SEG_INV = {(SEG_W+1){ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] SEL_INV = {N_DIGITS{ACTIVE_LOW}};
  localparam logic [SEG_W:0]      SEG_RST = {1'b0, SEG_TABLE[0]} ^ SEG_INV;
  localparam logic [N_DIGITS-1:0] SEL_RST = N_DIGITS'(1) ^ SEL_INV;

  // State
  logic [PRESC_W-1:0]       presc_q, presc_d;
  logic [N_DIGITS-1:0][3:0] count_q, count_d;
  logic                     dp_q, dp_d;
  logic [SCAN_W-1:0]        scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]         scan_idx_q, scan_idx_d;
  logic                     tick_q, tick_d;
  logic                     ovf_q, ovf_d;
  logic [SEG_W:0]           seg_q, seg_d;
  logic [N_DIGITS-1:0]      sel_q, sel_d;

  // Combinational helpers
  logic [N_DIGITS-1:0][3:0] w_count_inc;
  logic                     w_all_nines;
  logic                     w_carry;
  logic                     w_term;
  logic                     w_tick;
  logic [3:0]               w_digit;
  logic [N_DIGITS-1:0]      w_sel;
  logic                     w_blank;
  logic                     w_zero_above;
  logic [SEG_W-1:0]         w_seg7;
  logic [SEG_W:0]           w_seg_plain;

  // BCD +1 with ripple carry; a carry out of the top digit means all-9s
  always_comb begin
    w_count_inc = count_q;
    w_carry     = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (w_carry) begin
        if (count_q[k] == BCD_MAX) begin
          w_count_inc[k] = 4'd0;
        end else begin
          w_count_inc[k] = count_q[k] + 4'd1;
          w_carry        = 1'b0;
        end
      end
    end
    w_all_nines = w_carry;
  end

  // Prescaler terminal cycle; clear wins over a coincident tick
  assign w_term = bus.enable && (presc_q == PRESC_LAST);
  assign w_tick = w_term && !bus.clear;

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    dp_d    = dp_q;
    if (bus.clear) begin
      presc_d = '0;
      count_d = '0;
    end else if (bus.enable) begin
      if (w_term) begin
        presc_d = '0;
        count_d = w_count_inc;
        dp_d    = ~dp_q;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    tick_d = w_tick;
    ovf_d  = w_tick && w_all_nines;
  end

  // Free-running scan timer, independent of enable and clear
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end
  end

  // Digit mux plus leading-zero detection. Walking from the top digit down,
  // w_zero_above is true while this digit and every higher one are zero.
  always_comb begin
    w_digit      = '0;
    w_sel        = '0;
    w_blank      = 1'b0;
    w_zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_zero_above = w_zero_above && (count_q[k] == 4'd0);
      if (scan_idx_q == IDX_W'(k)) begin
        w_digit  = count_q[k];
        w_sel[k] = 1'b1;
        w_blank  = BLANK_LEADING && (k != 0) && w_zero_above;
      end
    end
  end

  seg7_decoder u_seg7_decoder (
    .digit_i (w_digit),
    .seg_o   (w_seg7)
  );

  always_comb begin
    w_seg_plain                = '0;
    w_seg_plain[SEG_G:SEG_A]   = w_blank ? '0 : w_seg7;
    w_seg_plain[SEG_DP]        = dp_q && w_sel[0];
    seg_d                      = w_seg_plain ^ SEG_INV;
    sel_d                      = w_sel ^ SEL_INV;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      presc_q    <= '0;
      count_q    <= '0;
      dp_q       <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      tick_q     <= 1'b0;
      ovf_q      <= 1'b0;
      seg_q      <= SEG_RST;
      sel_q      <= SEL_RST;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      dp_q       <= dp_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      tick_q     <= tick_d;
      ovf_q      <= ovf_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  assign bus.segment_out = seg_q;
  assign bus.digit_sel   = sel_q;
  assign bus.tick_out    = tick_q;
  assign bus.overflow    = ovf_q;

endmodule
`default_nettype wire
